conv1_window_sequencer: RTL and testbench

Control FSM that sequences one full convolution pass of the LeNet CONV1 datapath. It walks the output feature map in raster order and issues one kernel-window load per cycle to the image/weight ROM. It tracks results in flight through the DPU pipeline and writes each result into the output FIFO under credit-based flow control. It signals completion with a one-cycle `done` pulse.

---
 rtl/conv1_window_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_conv1_window_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_window_sequencer.sv
// conv1_window_sequencer
// Sequences one convolution pass of the CONV1 datapath: walks the output
// feature map in raster order (column fastest), issues one kernel-window
// load per cycle to the image/weight ROM, tracks results through the DPU
// pipeline and writes them into the output FIFO under credit flow control.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a pass (sampled only when idle)
//   busy       high from the cycle after accepted start until done inclusive
//   done       one-cycle pulse at end of pass
//   win_valid  ROM loads the window at (win_row, win_col) this cycle
//   win_row    signed window origin row    = out_row*STRIDE-PADDING
//   win_col    signed window origin column = out_col*STRIDE-PADDING
//   dpu_en     win_valid delayed DPU_LATENCY-1 cycles
//   fifo_wr    win_valid delayed DPU_LATENCY cycles
//   fifo_rd    consumer popped one FIFO entry (returns one credit)
//   out_count  number of fifo_wr pulses in the current pass
module conv1_window_sequencer #(
    parameter int unsigned IMAGE_WIDTH = 32,
    parameter int unsigned KERNEL_SIZE = 5,
    parameter int unsigned STRIDE      = 1,
    parameter int unsigned PADDING     = 0,
    parameter int unsigned DPU_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH  = 784,
    localparam int unsigned OUT_DIM = (IMAGE_WIDTH - KERNEL_SIZE + 2 * PADDING) / STRIDE + 1,
    localparam int unsigned CW      = $clog2(IMAGE_WIDTH + PADDING) + 1,
    localparam int unsigned NW      = $clog2(OUT_DIM * OUT_DIM + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 win_valid,
    output logic signed [CW-1:0] win_row,
    output logic signed [CW-1:0] win_col,
    output logic                 dpu_en,
    output logic                 fifo_wr,
    input  logic                 fifo_rd,
    output logic [NW-1:0]        out_count
);

    localparam int unsigned RCW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int unsigned CRW = $clog2(FIFO_DEPTH + 1);

    localparam logic [RCW-1:0] LAST_IDX   = RCW'(OUT_DIM - 1);
    localparam logic [CRW-1:0] CREDIT_MAX = CRW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [RCW-1:0]          out_row, out_row_nxt;
    logic [RCW-1:0]          out_col, out_col_nxt;
    logic [CRW-1:0]          credits, credits_nxt;
    logic [DPU_LATENCY-1:0]  pipe, pipe_nxt;
    logic                    win_valid_nxt;
    logic signed [CW-1:0]    win_row_nxt, win_col_nxt;
    logic                    busy_nxt, done_nxt;
    logic [NW-1:0]           out_count_nxt;
    logic                    want_issue;

    // Window origin from an output-map index (may be negative with padding).
    function automatic logic signed [CW-1:0] origin(input logic [RCW-1:0] idx);
        return $signed(CW'(32'(idx) * STRIDE)) - $signed(CW'(PADDING));
    endfunction

    // DPU enable taps the pipeline one stage before the FIFO write.
    if (DPU_LATENCY == 1) begin : g_dpu_direct
        assign dpu_en = win_valid;
    end else begin : g_dpu_pipe
        assign dpu_en = pipe[DPU_LATENCY-2];
    end
    assign fifo_wr = pipe[DPU_LATENCY-1];

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_row   <= '0;
            out_col   <= '0;
            credits   <= CREDIT_MAX;
            pipe      <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_count <= '0;
        end else begin
            state     <= state_nxt;
            out_row   <= out_row_nxt;
            out_col   <= out_col_nxt;
            credits   <= credits_nxt;
            pipe      <= pipe_nxt;
            win_valid <= win_valid_nxt;
            win_row   <= win_row_nxt;
            win_col   <= win_col_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            out_count <= out_count_nxt;
        end
    end

    // Next-state, counters, credits and next output values.
    always_comb begin
        state_nxt     = state;
        out_row_nxt   = out_row;
        out_col_nxt   = out_col;
        credits_nxt   = credits;
        pipe_nxt      = '0;
        win_row_nxt   = win_row;
        win_col_nxt   = win_col;
        out_count_nxt = out_count;
        want_issue    = 1'b0;

        // Credits: an issue consumes one, a pop returns one; a pop at full
        // credit with nothing issued has nothing to return.
        if (win_valid) begin
            credits_nxt = credits - CRW'(1) + CRW'(fifo_rd);
        end else if (fifo_rd && (credits != CREDIT_MAX)) begin
            credits_nxt = credits + CRW'(1);
        end

        // Result-in-flight shift register; bit i is win_valid delayed i+1.
        pipe_nxt[0] = win_valid;
        for (int unsigned i = 1; i < DPU_LATENCY; i++) begin
            pipe_nxt[i] = pipe[i-1];
        end

        if (fifo_wr) begin
            out_count_nxt = out_count + NW'(1);
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt     = S_ISSUE;
                    out_row_nxt   = '0;
                    out_col_nxt   = '0;
                    win_row_nxt   = origin('0);
                    win_col_nxt   = origin('0);
                    out_count_nxt = '0;
                    want_issue    = 1'b1;
                end
            end
            S_ISSUE: begin
                want_issue = 1'b1;
                if (win_valid) begin
                    if ((out_row == LAST_IDX) && (out_col == LAST_IDX)) begin
                        // Last window issued; coordinates hold on it.
                        state_nxt  = S_DRAIN;
                        want_issue = 1'b0;
                    end else begin
                        if (out_col == LAST_IDX) begin
                            out_col_nxt = '0;
                            out_row_nxt = out_row + RCW'(1);
                        end else begin
                            out_col_nxt = out_col + RCW'(1);
                        end
                        win_row_nxt = origin(out_row_nxt);
                        win_col_nxt = origin(out_col_nxt);
                    end
                end
            end
            S_DRAIN: begin
                // Leave once the final fifo_wr is on the outputs now.
                if (pipe_nxt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        win_valid_nxt = want_issue && (credits_nxt != '0);
        busy_nxt      = (state_nxt != S_IDLE);
        done_nxt      = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_conv1_window_sequencer.sv
// Self-checking bench for conv1_window_sequencer.
// dut_a: W=6 K=3 S=1 P=0 L=2 depth 64 (basic, start-ignored, reset, back-to-back)
// dut_b: W=6 K=3 S=2 P=1 L=2 depth 64 (stride and padding)
// dut_c: W=6 K=3 S=1 P=0 L=2 depth 4  (backpressure, credit restore)
module tb_conv1_window_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic              start_a, rd_a, busy_a, done_a, wv_a, dpu_a, wr_a;
    logic signed [3:0] row_a, col_a;
    logic [4:0]        cnt_a;
    logic              start_b, rd_b, busy_b, done_b, wv_b, dpu_b, wr_b;
    logic signed [3:0] row_b, col_b;
    logic [3:0]        cnt_b;
    logic              start_c, rd_c, busy_c, done_c, wv_c, dpu_c, wr_c;
    logic signed [3:0] row_c, col_c;
    logic [4:0]        cnt_c;

    conv1_window_sequencer #(
        .IMAGE_WIDTH(6), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(0),
        .DPU_LATENCY(2), .FIFO_DEPTH(64)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .win_valid(wv_a), .win_row(row_a), .win_col(col_a), .dpu_en(dpu_a),
        .fifo_wr(wr_a), .fifo_rd(rd_a), .out_count(cnt_a)
    );

    conv1_window_sequencer #(
        .IMAGE_WIDTH(6), .KERNEL_SIZE(3), .STRIDE(2), .PADDING(1),
        .DPU_LATENCY(2), .FIFO_DEPTH(64)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .win_valid(wv_b), .win_row(row_b), .win_col(col_b), .dpu_en(dpu_b),
        .fifo_wr(wr_b), .fifo_rd(rd_b), .out_count(cnt_b)
    );

    conv1_window_sequencer #(
        .IMAGE_WIDTH(6), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(0),
        .DPU_LATENCY(2), .FIFO_DEPTH(4)
    ) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
        .win_valid(wv_c), .win_row(row_c), .win_col(col_c), .dpu_en(dpu_c),
        .fifo_wr(wr_c), .fifo_rd(rd_c), .out_count(cnt_c)
    );

    // Advance one clock and land 1 time unit after the edge for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full basic pass on dut_a starting now (cycle 0); checks cycles 1..19.
    // With poke set, start is also raised during ISSUE (5) and DRAIN (17).
    task automatic run_basic_pass(input string tag, input bit poke);
        logic [4:0] exp_ctl;
        int         exp_cnt;
        start_a = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            start_a = poke && (c == 5 || c == 17);
            exp_ctl = {1'b1, (c == 19), (c <= 16), (c >= 2 && c <= 17), (c >= 3 && c <= 18)};
            exp_cnt = (c <= 3) ? 0 : c - 3;
            checks++;
            if ({busy_a, done_a, wv_a, dpu_a, wr_a} !== exp_ctl) begin
                failures++;
                $display("FAIL %s ctrl cyc=%0d busy/done/wv/dpu/wr got=%b exp=%b",
                         tag, c, {busy_a, done_a, wv_a, dpu_a, wr_a}, exp_ctl);
            end
            if (c <= 16) begin
                checks++;
                if (int'(row_a) !== (c - 1) / 4 || int'(col_a) !== (c - 1) % 4) begin
                    failures++;
                    $display("FAIL %s coord cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             tag, c, row_a, col_a, (c - 1) / 4, (c - 1) % 4);
                end
            end
            checks++;
            if (int'(cnt_a) !== exp_cnt) begin
                failures++;
                $display("FAIL %s out_count cyc=%0d got=%0d exp=%0d", tag, c, cnt_a, exp_cnt);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        rd_a = 1'b1; rd_b = 1'b1; rd_c = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({busy_a, done_a, wv_a, dpu_a, wr_a, busy_b, done_b, wv_b, dpu_b, wr_b,
             busy_c, done_c, wv_c, dpu_c, wr_c} !== 15'b0) begin
            failures++;
            $display("FAIL reset_ctrl got a=%b b=%b c=%b exp all zero",
                     {busy_a, done_a, wv_a, dpu_a, wr_a}, {busy_b, done_b, wv_b, dpu_b, wr_b},
                     {busy_c, done_c, wv_c, dpu_c, wr_c});
        end
        checks++;
        if ({row_a, col_a, row_b, col_b, row_c, col_c} !== 24'b0) begin
            failures++;
            $display("FAIL reset_coord got a=(%0d,%0d) b=(%0d,%0d) c=(%0d,%0d) exp zero",
                     row_a, col_a, row_b, col_b, row_c, col_c);
        end
        checks++;
        if (cnt_a !== 5'd0 || cnt_b !== 4'd0 || cnt_c !== 5'd0) begin
            failures++;
            $display("FAIL reset_count got a=%0d b=%0d c=%0d exp 0", cnt_a, cnt_b, cnt_c);
        end
    endtask

    task automatic test_basic();
        run_basic_pass("basic", 1'b0);
    endtask

    task automatic test_stride_pad();
        logic [4:0] exp_ctl;
        int         er, ec;
        start_b = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            start_b = 1'b0;
            exp_ctl = {(c <= 12), (c == 12), (c <= 9), (c >= 2 && c <= 10), (c >= 3 && c <= 11)};
            checks++;
            if ({busy_b, done_b, wv_b, dpu_b, wr_b} !== exp_ctl) begin
                failures++;
                $display("FAIL stride_pad ctrl cyc=%0d got=%b exp=%b",
                         c, {busy_b, done_b, wv_b, dpu_b, wr_b}, exp_ctl);
            end
            if (c <= 9) begin
                er = -1 + 2 * ((c - 1) / 3);
                ec = -1 + 2 * ((c - 1) % 3);
                checks++;
                if (int'(row_b) !== er || int'(col_b) !== ec) begin
                    failures++;
                    $display("FAIL stride_pad coord cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             c, row_b, col_b, er, ec);
                end
            end
        end
        checks++;
        if (cnt_b !== 4'd9) begin
            failures++;
            $display("FAIL stride_pad out_count got=%0d exp=9", cnt_b);
        end
    endtask

    // Depth 4, no pops: 4 windows then stall; a single pop in cycle 8 gives
    // one window at 9; pops from cycle 11 on give continuous issue 12..22
    // at credits=1 with no bubbles; last fifo_wr 24, done 25.
    task automatic test_backpressure();
        int idx = 0;
        int wr_total = 0;
        bit exp_wv;
        rd_c = 1'b0;
        start_c = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            tick();
            start_c = 1'b0;
            rd_c = (c == 8) || (c >= 11);
            exp_wv = (c <= 4) || (c == 9) || (c >= 12 && c <= 22);
            if (wr_c) wr_total++;
            checks++;
            if ({busy_c, done_c, wv_c} !== {(c <= 25), (c == 25), exp_wv}) begin
                failures++;
                $display("FAIL backpressure ctrl cyc=%0d busy/done/wv got=%b exp=%b",
                         c, {busy_c, done_c, wv_c}, {(c <= 25), (c == 25), exp_wv});
            end
            if (exp_wv) begin
                checks++;
                if (int'(row_c) !== idx / 4 || int'(col_c) !== idx % 4) begin
                    failures++;
                    $display("FAIL backpressure coord cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             c, row_c, col_c, idx / 4, idx % 4);
                end
                idx++;
            end
        end
        checks++;
        if (wr_total !== 16 || cnt_c !== 5'd16) begin
            failures++;
            $display("FAIL backpressure totals fifo_wr got=%0d out_count got=%0d exp=16",
                     wr_total, cnt_c);
        end
    endtask

    task automatic test_start_ignored();
        run_basic_pass("start_ignored", 1'b1);
    endtask

    task automatic test_reset_mid_pass();
        int  wv_total = 0;
        bit  seen_done = 1'b0;
        // Park dut_c in a credit stall so the reset must restore its credits.
        rd_c = 1'b0;
        start_c = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start_c = 1'b0;
        end
        checks++;
        if ({busy_c, wv_c} !== 2'b10) begin
            failures++;
            $display("FAIL mid_reset stall_c busy/wv got=%b exp=10", {busy_c, wv_c});
        end
        start_a = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start_a = 1'b0;
        end
        checks++;
        if ({wv_a, dpu_a, wr_a} !== 3'b111 || int'(row_a) !== 1 || int'(col_a) !== 2) begin
            failures++;
            $display("FAIL mid_reset window7 wv/dpu/wr got=%b at (%0d,%0d) exp=111 at (1,2)",
                     {wv_a, dpu_a, wr_a}, row_a, col_a);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy_a, done_a, wv_a, dpu_a, wr_a, row_a, col_a, cnt_a} !== 18'b0) begin
            failures++;
            $display("FAIL mid_reset outputs got ctl=%b row=%0d col=%0d cnt=%0d exp all zero",
                     {busy_a, done_a, wv_a, dpu_a, wr_a}, row_a, col_a, cnt_a);
        end
        checks++;
        if ({busy_c, wv_c} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset c_outputs busy/wv got=%b exp=00", {busy_c, wv_c});
        end
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if ({wr_a, wv_a, busy_a} !== 3'b000) begin
                failures++;
                $display("FAIL mid_reset quiet cyc=%0d wr/wv/busy got=%b exp=000",
                         c, {wr_a, wv_a, busy_a});
            end
        end
        // Restored credits: exactly FIFO_DEPTH=4 windows with no pops.
        start_c = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start_c = 1'b0;
            if (wv_c) wv_total++;
        end
        checks++;
        if (wv_total !== 4) begin
            failures++;
            $display("FAIL mid_reset credits windows got=%0d exp=4", wv_total);
        end
        rd_c = 1'b1;
        for (int c = 0; c < 100 && !seen_done; c++) begin
            tick();
            if (done_c) seen_done = 1'b1;
        end
        checks++;
        if (!seen_done) begin
            failures++;
            $display("FAIL mid_reset c_finish done got=0 exp=1 within 100 cycles");
        end
        tick();
        run_basic_pass("after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        tick();
        run_basic_pass("b2b_first", 1'b0);
        tick();
        checks++;
        if (busy_a !== 1'b0 || cnt_a !== 5'd16) begin
            failures++;
            $display("FAIL b2b idle busy=%b out_count=%0d exp busy=0 out_count=16", busy_a, cnt_a);
        end
        run_basic_pass("b2b_second", 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        tick();
        test_stride_pad();
        test_backpressure();
        tick();
        test_start_ignored();
        tick();
        test_reset_mid_pass();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
